sensor_responder: RTL and testbench

Sensor-side counterpart of the CGRA sensor context interface. Each CGRA cycle the context memory drives a sensor ID and a read strobe; this block answers with the sensor sample one cycle later. Samples arrive asynchronously to the schedule over a valid/ready write port. They are staged in shadow registers and published atomically on a frame sync, so a CGRA run always sees one consistent snapshot. The block sits between the sensor acquisition front end and the CGRA PE that consumes sensor values.

---
 rtl/sensor_responder_pkg.sv | 23 ++
 rtl/sensor_responder_if.sv | 28 ++
 rtl/sensor_responder_sensor_entry.sv | 52 +++++
 rtl/sensor_responder.sv | 98 +++++++++
 tb/tb_sensor_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_responder_pkg.sv
// Shared sensor-interface constants and types for the sensor responder slice.
// Holds the widths the CGRA sensor context and the responder agree on.
package sensor_responder_pkg;

   localparam int SENSOR_ID_WIDTH      = 4;
   localparam int SENSOR_CONTEXT_WIDTH = 8;
   localparam int SENSOR_DATA_WIDTH    = 32;

   // One registered read answer as seen by the consuming PE.
   typedef struct packed {
      logic [SENSOR_DATA_WIDTH-1:0] data;
      logic                         valid;
      logic                         fresh;
   } rd_result_t;

   // True when an ID addresses an implemented entry. The extra bit keeps
   // the compare correct when count equals 2**SENSOR_ID_WIDTH.
   function automatic logic id_in_range(input logic [SENSOR_ID_WIDTH-1:0] id,
                                        input int count);
      return ({1'b0, id} < (SENSOR_ID_WIDTH+1)'(count));
   endfunction

endpackage

// File: rtl/sensor_responder_if.sv
// Read port (context side) and sample write port (acquisition side) of the
// sensor responder, bundled so the top and its users share one definition.
interface sensor_responder_if;
   import sensor_responder_pkg::*;

   logic [SENSOR_ID_WIDTH-1:0]   SENSOR_ADDR_I;
   logic                         SENSOR_READ_EN_I;
   logic [SENSOR_DATA_WIDTH-1:0] SENSOR_DATA_O;
   logic                         SENSOR_DATA_VALID_O;
   logic                         SENSOR_FRESH_O;
   logic                         WR_VALID_I;
   logic                         WR_READY_O;
   logic [SENSOR_ID_WIDTH-1:0]   WR_ID_I;
   logic [SENSOR_DATA_WIDTH-1:0] WR_DATA_I;

   // Requester side: context memory plus acquisition front end.
   modport master (
      output SENSOR_ADDR_I, SENSOR_READ_EN_I, WR_VALID_I, WR_ID_I, WR_DATA_I,
      input  SENSOR_DATA_O, SENSOR_DATA_VALID_O, SENSOR_FRESH_O, WR_READY_O
   );

   // Responder side.
   modport slave (
      input  SENSOR_ADDR_I, SENSOR_READ_EN_I, WR_VALID_I, WR_ID_I, WR_DATA_I,
      output SENSOR_DATA_O, SENSOR_DATA_VALID_O, SENSOR_FRESH_O, WR_READY_O
   );

endinterface

// File: rtl/sensor_responder_sensor_entry.sv
// One sensor entry: shadow sample, published (active) sample, pending flag
// and freshness flag. Sync publishes the pre-write shadow; a fresh set by
// sync wins over a read clear in the same cycle.
module sensor_entry
   import sensor_responder_pkg::*;
(
   input  logic                         CGRA_CLK_I,
   input  logic                         RST_N_I,
   input  logic                         wr_en,
   input  logic [SENSOR_DATA_WIDTH-1:0] wr_data,
   input  logic                         sync,
   input  logic                         rd_clr,
   output logic [SENSOR_DATA_WIDTH-1:0] active_data,
   output logic                         fresh,
   output logic                         overrun_hit
);

   logic [SENSOR_DATA_WIDTH-1:0] shadow_reg, shadow_next;
   logic [SENSOR_DATA_WIDTH-1:0] active_reg, active_next;
   logic                         pend_reg, pend_next;
   logic                         fresh_reg, fresh_next;
   logic                         publish;

   // Next-state: publish first, then let a write land against post-sync pend.
   always_comb begin
      publish     = sync & pend_reg;
      overrun_hit = wr_en & pend_reg & ~sync;
      shadow_next = wr_en ? wr_data : shadow_reg;
      active_next = publish ? shadow_reg : active_reg;
      pend_next   = wr_en ? 1'b1 : (sync ? 1'b0 : pend_reg);
      fresh_next  = publish ? 1'b1 : (rd_clr ? 1'b0 : fresh_reg);
   end

   // Entry state registers.
   always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         shadow_reg <= '0;
         active_reg <= '0;
         pend_reg   <= 1'b0;
         fresh_reg  <= 1'b0;
      end else begin
         shadow_reg <= shadow_next;
         active_reg <= active_next;
         pend_reg   <= pend_next;
         fresh_reg  <= fresh_next;
      end
   end

   assign active_data = active_reg;
   assign fresh       = fresh_reg;

endmodule

// File: rtl/sensor_responder.sv
// Sensor responder: answers CGRA context sensor reads one cycle after the
// strobe from a snapshot published on SYNC_I. Entries are flip-flops so a
// sync can publish every entry in the same cycle.
module sensor_responder
   import sensor_responder_pkg::*;
#(
   parameter int SENSOR_COUNT = 16  // must not exceed 2**SENSOR_ID_WIDTH
) (
   input  logic                CGRA_CLK_I,
   input  logic                RST_N_I,
   input  logic                EN_I,
   input  logic                SYNC_I,
   input  logic                CLR_ERR_I,
   sensor_responder_if.slave   bus,
   output logic                OVERRUN_O,
   output logic                ADDR_ERR_O
);

   logic                         wr_fire, rd_fire;
   logic                         wr_in_range, rd_in_range;
   logic [SENSOR_COUNT-1:0]      entry_wr_en, entry_rd_clr;
   logic [SENSOR_COUNT-1:0]      entry_fresh, entry_overrun;
   logic [SENSOR_DATA_WIDTH-1:0] entry_active [SENSOR_COUNT];
   rd_result_t                   rd_mux, rd_next, rd_reg;
   logic                         wr_ready_reg;
   logic                         overrun_reg, overrun_next;
   logic                         addr_err_reg, addr_err_next;

   assign wr_fire     = bus.WR_VALID_I & wr_ready_reg;
   assign rd_fire     = EN_I & bus.SENSOR_READ_EN_I;
   assign wr_in_range = id_in_range(bus.WR_ID_I, SENSOR_COUNT);
   assign rd_in_range = id_in_range(bus.SENSOR_ADDR_I, SENSOR_COUNT);

   // Per-entry decode and storage; out-of-range IDs match no entry.
   generate
      for (genvar gi = 0; gi < SENSOR_COUNT; gi++) begin : g_entry
         assign entry_wr_en[gi]  = wr_fire & (bus.WR_ID_I == SENSOR_ID_WIDTH'(gi));
         assign entry_rd_clr[gi] = rd_fire & (bus.SENSOR_ADDR_I == SENSOR_ID_WIDTH'(gi));

         sensor_entry u_entry (
            .CGRA_CLK_I  (CGRA_CLK_I),
            .RST_N_I     (RST_N_I),
            .wr_en       (entry_wr_en[gi]),
            .wr_data     (bus.WR_DATA_I),
            .sync        (SYNC_I),
            .rd_clr      (entry_rd_clr[gi]),
            .active_data (entry_active[gi]),
            .fresh       (entry_fresh[gi]),
            .overrun_hit (entry_overrun[gi])
         );
      end
   endgenerate

   // Read mux; out-of-range reads answer zero data, not fresh.
   always_comb begin
      rd_mux       = '0;
      rd_mux.valid = rd_fire;
      if (rd_fire && rd_in_range) begin
         for (int i = 0; i < SENSOR_COUNT; i++) begin
            if (bus.SENSOR_ADDR_I == SENSOR_ID_WIDTH'(i)) begin
               rd_mux.data  = entry_active[i];
               rd_mux.fresh = entry_fresh[i];
            end
         end
      end
   end

   // Output and sticky-flag next state; data holds between reads.
   always_comb begin
      rd_next       = rd_fire ? rd_mux : '{data: rd_reg.data, valid: 1'b0, fresh: 1'b0};
      overrun_next  = (|entry_overrun) | (overrun_reg & ~CLR_ERR_I);
      addr_err_next = (wr_fire & ~wr_in_range) | (rd_fire & ~rd_in_range)
                    | (addr_err_reg & ~CLR_ERR_I);
   end

   // Output registers, write-ready and sticky error flags.
   always_ff @(posedge CGRA_CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         rd_reg       <= '0;
         wr_ready_reg <= 1'b0;
         overrun_reg  <= 1'b0;
         addr_err_reg <= 1'b0;
      end else begin
         rd_reg       <= rd_next;
         wr_ready_reg <= 1'b1;
         overrun_reg  <= overrun_next;
         addr_err_reg <= addr_err_next;
      end
   end

   assign bus.SENSOR_DATA_O       = rd_reg.data;
   assign bus.SENSOR_DATA_VALID_O = rd_reg.valid;
   assign bus.SENSOR_FRESH_O      = rd_reg.fresh;
   assign bus.WR_READY_O          = wr_ready_reg;
   assign OVERRUN_O               = overrun_reg;
   assign ADDR_ERR_O              = addr_err_reg;

endmodule

// File: tb/tb_sensor_responder.sv
// Directed bench for sensor_responder with a transaction-level model of the
// entry table; outputs are compared against the model on every falling edge.
module tb_sensor_responder;
   import sensor_responder_pkg::*;

   localparam int CNT = 12;

   logic clk = 1'b0;
   logic rst_n;
   logic en, sync, clr_err;
   logic ovr_o, aerr_o;

   sensor_responder_if bus ();

   sensor_responder #(.SENSOR_COUNT(CNT)) dut (
      .CGRA_CLK_I (clk),
      .RST_N_I    (rst_n),
      .EN_I       (en),
      .SYNC_I     (sync),
      .CLR_ERR_I  (clr_err),
      .bus        (bus),
      .OVERRUN_O  (ovr_o),
      .ADDR_ERR_O (aerr_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   // Model: what each sensor entry holds, and what the outputs must show.
   logic [31:0] m_shadow [16];
   logic [31:0] m_active [16];
   bit          m_pend   [16];
   bit          m_fresh  [16];
   logic [31:0] exp_data;
   bit          exp_valid, exp_fresh, exp_ovr, exp_aerr, exp_ready;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_shadow[i] = '0; m_active[i] = '0; m_pend[i] = 0; m_fresh[i] = 0;
      end
      exp_data = '0; exp_valid = 0; exp_fresh = 0;
      exp_ovr = 0; exp_aerr = 0; exp_ready = 0;
   endtask

   // One clock edge of behaviour: read sees the old snapshot, sync publishes
   // pending samples, then a write lands in the shadow.
   task automatic model_step();
      bit ovr_evt, aerr_evt, wr_fire;
      int a, w;
      if (!rst_n) return;
      ovr_evt  = 0;
      aerr_evt = 0;
      wr_fire  = bus.WR_VALID_I && exp_ready;
      if (en && bus.SENSOR_READ_EN_I) begin
         a = int'(bus.SENSOR_ADDR_I);
         exp_valid = 1;
         if (a < CNT) begin
            exp_data = m_active[a]; exp_fresh = m_fresh[a]; m_fresh[a] = 0;
         end else begin
            exp_data = '0; exp_fresh = 0; aerr_evt = 1;
         end
      end else begin
         exp_valid = 0; exp_fresh = 0;
      end
      if (sync) begin
         for (int i = 0; i < CNT; i++) begin
            if (m_pend[i]) begin
               m_active[i] = m_shadow[i]; m_fresh[i] = 1; m_pend[i] = 0;
            end
         end
      end
      if (wr_fire) begin
         w = int'(bus.WR_ID_I);
         if (w < CNT) begin
            if (m_pend[w]) ovr_evt = 1;
            m_shadow[w] = bus.WR_DATA_I; m_pend[w] = 1;
         end else begin
            aerr_evt = 1;
         end
      end
      exp_ovr   = ovr_evt  | (exp_ovr  & ~clr_err);
      exp_aerr  = aerr_evt | (exp_aerr & ~clr_err);
      exp_ready = 1;
   endtask

   // Compare process: every falling edge the outputs must match the model.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("data",  bus.SENSOR_DATA_O,              exp_data);
         chk("valid", {31'b0, bus.SENSOR_DATA_VALID_O}, {31'b0, exp_valid});
         chk("fresh", {31'b0, bus.SENSOR_FRESH_O},      {31'b0, exp_fresh});
         chk("ovr",   {31'b0, ovr_o},                   {31'b0, exp_ovr});
         chk("aerr",  {31'b0, aerr_o},                  {31'b0, exp_aerr});
         chk("ready", {31'b0, bus.WR_READY_O},          {31'b0, exp_ready});
      end
   end

   // Advance one edge; return 1 time unit after it so inputs never race it.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_write(input int id, input logic [31:0] d);
      bus.WR_VALID_I = 1; bus.WR_ID_I = 4'(id); bus.WR_DATA_I = d;
      tick();
      bus.WR_VALID_I = 0;
   endtask

   task automatic do_sync();
      sync = 1;
      tick();
      sync = 0;
   endtask

   task automatic do_read(input int id);
      en = 1; bus.SENSOR_READ_EN_I = 1; bus.SENSOR_ADDR_I = 4'(id);
      tick();
      bus.SENSOR_READ_EN_I = 0;
   endtask

   task automatic lit(input string name, input logic [31:0] d, input bit v, input bit f);
      chk({name, ".data"},  bus.SENSOR_DATA_O, d);
      chk({name, ".valid"}, {31'b0, bus.SENSOR_DATA_VALID_O}, {31'b0, v});
      chk({name, ".fresh"}, {31'b0, bus.SENSOR_FRESH_O},      {31'b0, f});
   endtask

   initial begin
      rst_n = 0; en = 0; sync = 0; clr_err = 0;
      bus.SENSOR_ADDR_I = '0; bus.SENSOR_READ_EN_I = 0;
      bus.WR_VALID_I = 0; bus.WR_ID_I = '0; bus.WR_DATA_I = '0;
      model_reset();
      #1 chk_on = 1;
      chk("rst.ready", {31'b0, bus.WR_READY_O}, 32'd0);
      tick(); tick();
      rst_n = 1;
      tick();
      chk("ready_up", {31'b0, bus.WR_READY_O}, 32'd1);

      // Read after reset: zero data, valid, not fresh, no flags.
      do_read(3);
      lit("rd3_rst", 32'h0, 1, 0);
      chk("rd3_rst.flags", {30'b0, ovr_o, aerr_o}, 32'd0);
      tick();
      lit("idle", 32'h0, 0, 0);

      // Publish and consume one sample.
      do_write(3, 32'hA5A5_0001);
      do_read(3);
      lit("pre_sync", 32'h0, 1, 0);
      do_sync();
      do_read(3);
      lit("rd3_a", 32'hA5A5_0001, 1, 1);
      do_read(3);
      lit("rd3_b", 32'hA5A5_0001, 1, 0);

      // Overrun on double write before sync.
      do_write(5, 32'h11);
      do_write(5, 32'h22);
      chk("ovr_set", {31'b0, ovr_o}, 32'd1);
      do_sync();
      do_read(5);
      lit("rd5", 32'h22, 1, 1);
      clr_err = 1; tick(); clr_err = 0;
      chk("ovr_clr", {31'b0, ovr_o}, 32'd0);

      // Write in the same cycle as sync is held for the next sync.
      do_write(7, 32'h10);
      do_sync();
      bus.WR_VALID_I = 1; bus.WR_ID_I = 4'd7; bus.WR_DATA_I = 32'h20; sync = 1;
      tick();
      bus.WR_VALID_I = 0; sync = 0;
      chk("ovr_none", {31'b0, ovr_o}, 32'd0);
      do_read(7);
      lit("rd7_old", 32'h10, 1, 1);
      do_sync();
      do_read(7);
      lit("rd7_new", 32'h20, 1, 1);

      // Read and sync on the same entry: old value, fresh re-armed.
      do_write(4, 32'h44); do_sync(); do_read(4);
      do_write(4, 32'h45);
      en = 1; bus.SENSOR_READ_EN_I = 1; bus.SENSOR_ADDR_I = 4'd4; sync = 1;
      tick();
      bus.SENSOR_READ_EN_I = 0; sync = 0;
      lit("rd4_sync", 32'h44, 1, 0);
      do_read(4);
      lit("rd4_next", 32'h45, 1, 1);

      // Back-to-back strobes with EN_I dropping on the third.
      do_write(0, 32'hA0); do_write(1, 32'hB1); do_write(2, 32'hC2); do_sync();
      en = 1; bus.SENSOR_READ_EN_I = 1; bus.SENSOR_ADDR_I = 4'd0;
      tick();
      lit("b2b0", 32'hA0, 1, 1);
      bus.SENSOR_ADDR_I = 4'd1;
      tick();
      lit("b2b1", 32'hB1, 1, 1);
      bus.SENSOR_ADDR_I = 4'd2; en = 0;
      tick();
      lit("b2b2", 32'hB1, 0, 0);
      bus.SENSOR_READ_EN_I = 0; en = 1;

      // Out-of-range write and read; no in-range entry changes.
      do_write(13, 32'hDEAD_BEEF);
      chk("aerr_wr", {31'b0, aerr_o}, 32'd1);
      clr_err = 1; tick(); clr_err = 0;
      chk("aerr_clr", {31'b0, aerr_o}, 32'd0);
      do_read(14);
      lit("rd14", 32'h0, 1, 0);
      chk("aerr_rd", {31'b0, aerr_o}, 32'd1);
      do_sync();
      for (int i = 0; i < CNT; i++) do_read(i);
      clr_err = 1; bus.WR_VALID_I = 1; bus.WR_ID_I = 4'd15;
      tick();
      clr_err = 0; bus.WR_VALID_I = 0;
      chk("aerr_prio", {31'b0, aerr_o}, 32'd1);

      // Reset mid-frame with pending and active samples.
      do_write(9, 32'h99);
      do_read(3);
      #2 rst_n = 0;
      model_reset();
      #1;
      lit("rst_mid", 32'h0, 0, 0);
      chk("rst_mid.flags", {29'b0, ovr_o, aerr_o, bus.WR_READY_O}, 32'd0);
      tick();
      rst_n = 1;
      tick();
      do_sync();
      do_read(3);
      lit("rd3_after_rst", 32'h0, 1, 0);
      do_read(9);
      lit("rd9_after_rst", 32'h0, 1, 0);
      tick();

      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
